// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// inst_fetch_pkg : reset PC, fetch FSM encodings, queue entry type
// Rev 1.0
// ============================================================================
package inst_fetch_pkg;

    localparam logic [31:0] C_RESET_PC = 32'h00400020;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_DROP = 2'd2
    } if_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// inst_queue : 2-entry {pc, inst} FIFO with push, pop, clear and count
// Rev 1.0
// ============================================================================
module inst_queue
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;
    logic         w_push;
    logic         w_pop;

    assign w_push = push && (r_count != 2'd2);
    assign w_pop  = pop  && (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (clear) begin
            // clear overrides any concurrent push/pop
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= wr_entry;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// inst_fetch : fetch PC, imem req/ack sequencing, redirect handling
// Rev 1.0
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = C_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    if_state_t    r_state;
    if_state_t    w_next_state;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_drop_addr;
    logic [1:0]   w_count;
    fetch_entry_t w_head;
    fetch_entry_t w_wr_entry;
    logic         w_ack_req;
    logic         w_push;
    logic         w_pop;
    logic [2:0]   w_next_count;
    logic         w_room;
    logic         w_unused_bits;

    assign w_ack_req    = (r_state == IF_REQ) && imem_ack;
    assign w_pop        = inst_valid && inst_ready;
    assign w_push       = w_ack_req && !redirect_valid;
    assign w_next_count = {1'b0, w_count} + 3'(w_push) - 3'(w_pop);
    assign w_room       = w_next_count < 3'(QDEPTH);
    assign w_wr_entry   = '{pc: r_fetch_pc, inst: imem_rdata};
    assign w_unused_bits = ^redirect_pc[1:0];

    always_comb begin
        w_next_state = r_state;
        if (redirect_valid) begin
            // an unacked request must still complete with its old address
            case (r_state)
                IF_REQ:  w_next_state = imem_ack ? IF_REQ : IF_DROP;
                IF_DROP: w_next_state = IF_DROP;
                default: w_next_state = IF_REQ;
            endcase
        end else begin
            case (r_state)
                IF_IDLE: w_next_state = w_room ? IF_REQ : IF_IDLE;
                IF_REQ:  w_next_state = (imem_ack && !w_room) ? IF_IDLE : IF_REQ;
                IF_DROP: w_next_state = imem_ack ? IF_REQ : IF_DROP;
                default: w_next_state = IF_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IF_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_drop_addr <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            if (redirect_valid) begin
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (w_ack_req) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            // frozen in DROP so the outstanding address stays stable
            if (r_state != IF_DROP) begin
                r_drop_addr <= r_fetch_pc;
            end
        end
    end

    inst_queue u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .clear    (redirect_valid),
        .wr_entry (w_wr_entry),
        .head     (w_head),
        .count    (w_count)
    );

    assign imem_req   = (r_state != IF_IDLE);
    assign imem_addr  = (r_state == IF_DROP) ? r_drop_addr : r_fetch_pc;
    assign inst_valid = (w_count != 2'd0);
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch : scoreboard bench for inst_fetch with latency-controlled memory
// Rev 1.0
// ============================================================================
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int latency = 0;
    int wait_cnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    // memory acks once the request has waited `latency` cycles
    assign imem_ack   = imem_req && (wait_cnt >= latency);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or posedge rst) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                              wait_cnt <= wait_cnt + 1;
    end

    // monitor: every accepted instruction must be the next expected one
    always @(negedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect_valid) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_inst: got pc=%h inst=%h, required no delivery", inst_pc, inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst) begin
                    n_fail++;
                    $display("FAIL deliver: got pc=%h inst=%h, required pc=%h inst=%h",
                             inst_pc, inst, e.pc, e.inst);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc   = start + 32'(4 * i);
            e.inst = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    initial begin
        rst            = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) tick;
        check("rst_req",   32'(imem_req),   32'h0);
        check("rst_addr",  imem_addr,       32'h00400020);
        check("rst_valid", 32'(inst_valid), 32'h0);
        check("rst_inst",  inst,            32'h0);
        check("rst_pc",    inst_pc,         32'h0);

        // sequential stream, then backpressure
        expect_seq(32'h00400020, 5);
        rst = 1'b0;
        tick;
        check("first_req",  32'(imem_req), 32'h1);
        check("addr0",      imem_addr, 32'h00400020);
        tick;
        check("addr1",      imem_addr, 32'h00400024);
        check("head_pc0",   inst_pc,   32'h00400020);
        tick;
        check("addr2",      imem_addr, 32'h00400028);
        check("head_pc1",   inst_pc,   32'h00400024);
        inst_ready = 1'b0;
        tick;
        check("full_req",   32'(imem_req),   32'h0);
        check("full_valid", 32'(inst_valid), 32'h1);
        check("full_head",  inst_pc,         32'h00400024);
        tick;
        check("full_hold",  32'(imem_req),   32'h0);
        inst_ready = 1'b1;
        tick;
        check("resume_req",  32'(imem_req), 32'h1);
        check("resume_addr", imem_addr,     32'h0040002C);
        tick;
        tick;
        check("stall_addr", imem_addr, 32'h00400034);
        latency = 3;

        // redirect while a request is waiting: stale ack must be dropped
        tick;
        check("drained",    32'(exp_q.size()), 32'h0);
        check("wait_addr",  imem_addr, 32'h00400034);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00400103;
        tick;
        redirect_valid = 1'b0;
        check("drop_req",   32'(imem_req),   32'h1);
        check("drop_addr",  imem_addr,       32'h00400034);
        check("drop_valid", 32'(inst_valid), 32'h0);
        tick;
        check("drop_ack_addr", imem_addr, 32'h00400034);
        tick;
        check("refetch_addr",  imem_addr,       32'h00400100);
        check("refetch_valid", 32'(inst_valid), 32'h0);

        // fill the queue, then redirect with a concurrent pop
        latency    = 0;
        inst_ready = 1'b0;
        tick;
        check("fill_addr",  imem_addr, 32'h00400104);
        check("fill_head",  inst_pc,   32'h00400100);
        tick;
        check("fill_req",   32'(imem_req),   32'h0);
        check("fill_valid", 32'(inst_valid), 32'h1);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h00400200;
        tick;
        redirect_valid = 1'b0;
        check("flush_valid", 32'(inst_valid), 32'h0);
        check("flush_req",   32'(imem_req),   32'h1);
        check("flush_addr",  imem_addr,       32'h00400200);
        tick;
        check("ackpop_addr", imem_addr, 32'h00400204);
        check("ackpop_head", inst_pc,   32'h00400200);

        // redirect coincident with ack + pop, target at top of address space
        expect_seq(32'hFFFFFFFC, 1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFFFFFE;
        tick;
        redirect_valid = 1'b0;
        check("wrap_valid", 32'(inst_valid), 32'h0);
        check("wrap_addr0", imem_addr,       32'hFFFFFFFC);
        tick;
        check("wrap_addr1", imem_addr, 32'h00000000);
        check("wrap_head",  inst_pc,   32'hFFFFFFFC);
        tick;
        check("pre_rst_req", 32'(imem_req), 32'h1);

        // asynchronous reset mid-request with one queued entry
        rst = 1'b1;
        #1;
        check("arst_req",   32'(imem_req),   32'h0);
        check("arst_valid", 32'(inst_valid), 32'h0);
        check("arst_addr",  imem_addr,       32'h00400020);
        check("arst_drained", 32'(exp_q.size()), 32'h0);
        tick;
        tick;
        expect_seq(32'h00400020, 1);
        rst = 1'b0;
        tick;
        check("rerst_req",  32'(imem_req), 32'h1);
        check("rerst_addr", imem_addr,     32'h00400020);
        tick;
        check("rerst_head", inst_pc,   32'h00400020);
        check("rerst_addr1", imem_addr, 32'h00400024);
        latency = 1000;
        tick;
        tick;
        check("hold_addr",  imem_addr, 32'h00400024);
        check("end_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
